// File: rtl/ascon_perm_iter_if.sv
// ascon_perm_iter_if: start/done job interface between the mode FSM and the ASCON permutation core.
// ASCON_XOR_IN_EN adds the input/output XOR injection signals.
interface ascon_perm_iter_if;
    logic         start_i;
    logic         mode_i;
    logic [319:0] state_i;
    logic         ready_o;
    logic         valid_o;
    logic [319:0] state_o;
`ifdef ASCON_XOR_IN_EN
    logic [319:0] xor_begin_i;
    logic [319:0] xor_end_i;
    modport master (output start_i, mode_i, state_i, xor_begin_i, xor_end_i, input ready_o, valid_o, state_o);
    modport slave (input start_i, mode_i, state_i, xor_begin_i, xor_end_i, output ready_o, valid_o, state_o);
`else
    modport master (output start_i, mode_i, state_i, input ready_o, valid_o, state_o);
    modport slave (input start_i, mode_i, state_i, output ready_o, valid_o, state_o);
`endif
endinterface

// File: rtl/ascon_perm_iter.sv
// ascon_perm_iter: iterative ASCON p12/p6 permutation, UNROLL rounds per clock.
// ASCON_XOR_IN_EN: XOR xor_begin_i into the loaded state and xor_end_i into the result.
module ascon_perm_iter #(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 4
) (
    input logic clock_i,
    input logic reset_i,
    ascon_perm_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [7:0] RC [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                       8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    localparam logic [4:0] SBOX_C [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
        $error("ascon_perm_iter: UNROLL must be 1, 2, 3 or 6");
    end
    if (CNT_W < 4) begin : g_bad_cnt
        $error("ascon_perm_iter: CNT_W must hold 0..12");
    end

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [7:0] rc_at(input logic [CNT_W-1:0] i);
        return (i < CNT_W'(12)) ? RC[i[3:0]] : 8'h00;
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] rc);
        logic [63:0] x [5];
        logic [4:0]  col;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        x[2] = x[2] ^ {56'h0, rc};
        for (int j = 0; j < 64; j++) begin
            col = SBOX_C[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
            for (int i = 0; i < 5; i++) x[i][j] = col[4 - i];
        end
        x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
        x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
        x[2] = x[2] ^ ror(x[2], 1) ^ ror(x[2], 6);
        x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
        x[4] = x[4] ^ ror(x[4], 7) ^ ror(x[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    fsm_t             fsm, fsm_n;
    logic [CNT_W-1:0] r, r_n;
    logic [319:0]     st, st_n, res, res_n, nxt, xb, xe;
    logic             last;

`ifdef ASCON_XOR_IN_EN
    assign xb = bus.xor_begin_i;
    assign xe = bus.xor_end_i;
`else
    assign xb = '0;
    assign xe = '0;
`endif

    always_comb begin
        nxt = st;
        for (int k = 0; k < UNROLL; k++) nxt = ascon_round(nxt, rc_at(r + CNT_W'(k)));
    end

    assign last = (r + CNT_W'(UNROLL)) == CNT_W'(12);

    always_comb begin
        fsm_n = fsm;
        st_n  = st;
        r_n   = r;
        res_n = res;
        if (fsm == RUN) begin
            st_n = nxt;
            r_n  = r + CNT_W'(UNROLL);
            if (last) begin
                fsm_n = DONE;
                res_n = nxt ^ xe;
            end
        end else if (bus.start_i) begin
            st_n  = bus.state_i ^ xb;
            r_n   = bus.mode_i ? CNT_W'(6) : '0;
            fsm_n = RUN;
        end else if (fsm == DONE) begin
            fsm_n = IDLE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm <= IDLE;
            st  <= '0;
            r   <= '0;
            res <= '0;
        end else begin
            fsm <= fsm_n;
            st  <= st_n;
            r   <= r_n;
            res <= res_n;
        end
    end

    assign bus.ready_o = fsm != RUN;
    assign bus.valid_o = fsm == DONE;
    assign bus.state_o = res;
endmodule

// File: doc/ascon_perm_iter.md
Name: ascon_perm_iter

Overview:
- Iterative, parametrised ASCON permutation core for the ASCON-128 datapath.
- Built on the shared package: 320-bit state type, 12-entry round-constant table and 32-entry S-box table.
- Computes p^12 or p^6, selected per job, with UNROLL rounds evaluated combinationally per clock.
- Start/done handshake toward the mode FSM, which supplies the state and consumes the result.

Parameters:
- UNROLL, 1: rounds per clock. Legal values are 1, 2, 3, 6. Any other value is an elaboration error.
- CNT_W, 4: width of the round-index counter. Must hold values 0..12.

Ports:
- clock_i  in  1  system clock. Single clock domain; reset is synchronous and active-high.
- reset_i  in  1  synchronous active-high reset, sampled on the rising edge of clock_i.
- start_i  in  1  job request. Accepted only when ready_o=1.
- mode_i  in  1  0: 12 rounds (constants 0..11). 1: 6 rounds (constants 6..11).
- state_i  in  320  input state, word 0 first (type_state ordering).
- ready_o  out  1  core can accept start_i this cycle.
- valid_o  out  1  result valid. One-cycle pulse.
- state_o  out  320  permutation result. Held stable until the next accepted start.

Behaviour:
- Reset: FSM=IDLE, ready_o=1, valid_o=0, state_o=0, state register=0, round index=0.
- Round (per unrolled stage, index r):
  - x2 ^= {56'h0, round_constant[r]}.
  - S-box on 64 columns j: {x0[j],x1[j],x2[j],x3[j],x4[j]} (x0 = MSB) is replaced by sbox_c[that value].
  - Linear layer, rotate right:
    - x0 ^= ror19 ^ ror28
    - x1 ^= ror61 ^ ror39
    - x2 ^= ror1 ^ ror6
    - x3 ^= ror10 ^ ror17
    - x4 ^= ror7 ^ ror41
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start_i=1:
  - state_reg <= state_i.
  - r <= (mode_i ? 6 : 0).
  - FSM -> RUN.
  - mode_i and state_i are sampled only at this edge.
- RUN, each edge:
  - state_reg <= UNROLL rounds applied with indices r..r+UNROLL-1.
  - r <= r+UNROLL.
  - When r+UNROLL == 12: FSM -> DONE.
- DONE, on entry:
  - state_o <= result, registered on the edge that enters DONE.
  - valid_o=1 for exactly one cycle.
- DONE with start_i=0: FSM -> IDLE.
- DONE with start_i=1: back-to-back job. New load happens at that edge, FSM -> RUN.
- ready_o = 1 in IDLE and DONE, 0 in RUN.
- start_i while in RUN is ignored; no queuing.
- Latency: accept edge E0, RUN edges E1..EN with N = rounds/UNROLL. valid_o is high in the cycle following EN.
  - UNROLL=1: N=12 (p12) or 6 (p6).
  - UNROLL=2: N=6 or 3.
  - UNROLL=3: N=4 or 2.
  - UNROLL=6: N=2 or 1.
- Round index never exceeds 12. No wrap-around.
- reset_i asserted mid-RUN:
  - Next edge returns all outputs to reset values.
  - Job discarded; no valid_o pulse.
  - reset_i has priority over start_i.
- Throughput, back-to-back: one result every N+1 cycles.

Optional Feature:
- Macro: ASCON_XOR_IN_EN.
- Defined:
  - Extra inputs xor_begin_i (320) and xor_end_i (320).
  - At accept: state_reg <= state_i ^ xor_begin_i.
  - At the DONE-entry edge: state_o <= result ^ xor_end_i, with xor_end_i sampled at that edge.
  - Supports data, key and domain-separation injection without external XOR stages.
- Not defined:
  - Ports absent. Behaviour exactly as above.
  - No area cost.

Test Plan:
- Reset, then idle 5 cycles -> ready_o=1, valid_o=0, state_o=0 throughout.
- UNROLL=1, mode_i=0, state_i=0 -> valid_o pulses in cycle 13 after accept, ready_o=0 for 12 cycles, state_o equals golden model p12(0). Repeat with mode_i=1 -> pulse in cycle 7, result = golden p6(0).
- Sweep UNROLL in {2,3,6} with state_i = ASCON-128 IV||K||N (word0=64'h80400C0600000000, K=N=128'h000102..0F) -> state_o matches the UNROLL=1 result bit-exact. Pulse at cycle N+1 with N = 6/4/2 for p12 and 3/2/1 for p6.
- Hold start_i=1 continuously with alternating mode_i -> jobs start at each DONE, one result every N+1 cycles. Starts during RUN ignored; mode changes during RUN have no effect.
- Assert reset_i at RUN cycle 3 (UNROLL=1) -> next cycle state_o=0, ready_o=1, no valid_o pulse. A fresh start then produces the correct result.
- ASCON_XOR_IN_EN defined, xor_begin_i = state_i (zero-effective input), xor_end_i = 320'h1 -> state_o = p12(0) ^ 1. Macro undefined -> bench compiles without those ports.
